// File: rtl/mips_top.sv
// mips_top: single-cycle MIPS32 integer ALU core fetching from a unified word-addressed RAM
module mips_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:(1<<AW)-1];
  assign rdata = memory[raddr];
  // Optional write port; reset never touches the contents
  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];
  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
  // Register write; $0 is hardwired so its writes are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  end
endmodule

module mips_core #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] iaddr,
  input  logic [31:0]   inst
);
  logic [31:0] pc, pc_d;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa, wa;
  logic [15:0] imm;
  logic [31:0] a, b, imm_s, imm_z, sum, dif, sumi, res;
  logic        ovf_add, ovf_sub, ovf_addi, we;
  assign {op, rs, rt, rd, sa, funct} = inst;
  assign imm      = inst[15:0];
  assign imm_s    = {{16{imm[15]}}, imm};
  assign imm_z    = {16'h0, imm};
  assign sum      = a + b;
  assign dif      = a - b;
  assign sumi     = a + imm_s;
  assign ovf_add  = (a[31] == b[31]) && (sum[31] != a[31]);
  assign ovf_sub  = (a[31] != b[31]) && (dif[31] != a[31]);
  assign ovf_addi = (a[31] == imm_s[31]) && (sumi[31] != a[31]);
  assign iaddr    = pc[AW+1:2];
  mips_regfile regfile (
    .clk, .rst, .ra1(rs), .ra2(rt), .wa, .we, .wd(res), .rd1(a), .rd2(b)
  );
  // Decode and execute; unknown encodings and signed overflow leave we low
  always_comb begin
    res = '0;
    wa  = rt;
    we  = 1'b0;
    if (op == 6'h00) begin
      wa = rd;
      we = 1'b1;
      case (funct)
        6'h20: begin res = sum; we = ~ovf_add; end
        6'h21: res = sum;
        6'h22: begin res = dif; we = ~ovf_sub; end
        6'h23: res = dif;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2a: res = {31'b0, $signed(a) < $signed(b)};
        6'h2b: res = {31'b0, a < b};
        6'h00: res = b << sa;
        6'h02: res = b >> sa;
        6'h03: res = $signed(b) >>> sa;
        6'h04: res = b << a[4:0];
        6'h06: res = b >> a[4:0];
        6'h07: res = $signed(b) >>> a[4:0];
        default: we = 1'b0;
      endcase
    end else begin
      we = 1'b1;
      case (op)
        6'h08: begin res = sumi; we = ~ovf_addi; end
        6'h09: res = sumi;
        6'h0a: res = {31'b0, $signed(a) < $signed(imm_s)};
        6'h0b: res = {31'b0, a < imm_s};
        6'h0c: res = a & imm_z;
        6'h0d: res = a | imm_z;
        6'h0e: res = a ^ imm_z;
        6'h0f: res = {imm, 16'h0};
        default: we = 1'b0;
      endcase
    end
  end
  // Every instruction completes in one cycle, so the PC always steps by a word
  always_comb pc_d = pc + 32'd4;
  // Program counter with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else pc <= pc_d;
  end
endmodule

module mips_top #(
  parameter int RAM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [AW-1:0] iaddr;
  logic [31:0]   inst;
  mips_ram #(.AW(AW)) ram (
    .clk, .we(1'b0), .waddr('0), .wdata('0), .raddr(iaddr), .rdata(inst)
  );
  mips_core #(.AW(AW)) openmips (
    .clk, .rst, .iaddr, .inst
  );
endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: directed vectors, corner sequences and random programs against a reference model
module tb_mips_top;
  localparam int N = 64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_regs [32];
  logic [31:0] snap [32];
  logic [31:0] prog [48];

  mips_top #(.RAM_WORDS(N)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] rt_op(input logic [5:0] f, input int rd, input int rs, input int rt, input int sa);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sa), f};
  endfunction

  function automatic logic [31:0] it_op(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] sra_m(input logic [31:0] x, input int n);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (x >> n) | (x[31] ? ~(ones >> n) : 32'h0);
  endfunction

  // Architectural model: decode from the field rules, overflow via 64-bit range check
  task automatic m_step(input logic [31:0] ins);
    logic [31:0] a, b, v, se, ze;
    longint s;
    int d;
    bit wr;
    a  = m_regs[ins[25:21]];
    b  = m_regs[ins[20:16]];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    wr = 1'b1;
    v  = '0;
    if (ins[31:26] == 6'h00) begin
      d = int'(ins[15:11]);
      case (ins[5:0])
        6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); v = s[31:0]; wr = (s >= -64'sd2147483648) && (s <= 64'sd2147483647); end
        6'h21: v = a + b;
        6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); v = s[31:0]; wr = (s >= -64'sd2147483648) && (s <= 64'sd2147483647); end
        6'h23: v = a - b;
        6'h24: v = a & b;
        6'h25: v = a | b;
        6'h26: v = a ^ b;
        6'h27: v = ~(a | b);
        6'h2a: v = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        6'h2b: v = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
        6'h00: v = b << ins[10:6];
        6'h02: v = b >> ins[10:6];
        6'h03: v = sra_m(b, int'(ins[10:6]));
        6'h04: v = b << a[4:0];
        6'h06: v = b >> a[4:0];
        6'h07: v = sra_m(b, int'(a[4:0]));
        default: wr = 1'b0;
      endcase
    end else begin
      d = int'(ins[20:16]);
      case (ins[31:26])
        6'h08: begin s = longint'($signed(a)) + longint'($signed(se)); v = s[31:0]; wr = (s >= -64'sd2147483648) && (s <= 64'sd2147483647); end
        6'h09: v = a + se;
        6'h0a: v = (int'(a) < int'(se)) ? 32'd1 : 32'd0;
        6'h0b: v = (longint'(a) < longint'(se)) ? 32'd1 : 32'd0;
        6'h0c: v = a & ze;
        6'h0d: v = a | ze;
        6'h0e: v = a ^ ze;
        6'h0f: v = {ins[15:0], 16'h0};
        default: wr = 1'b0;
      endcase
    end
    if (wr && d != 0) m_regs[d] = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [31:0] exp_pc);
    int bad;
    bad = -1;
    for (int i = 0; i < 32; i++) if (dut.openmips.regfile.regs[i] !== m_regs[i] && bad < 0) bad = i;
    n_cmp++;
    if (bad >= 0 || dut.openmips.pc !== exp_pc) begin
      n_bad++;
      if (bad < 0) bad = 0;
      $display("FAIL %s: pc %h (expected %h) r%0d %h (expected %h)", nm, dut.openmips.pc, exp_pc,
               bad, dut.openmips.regfile.regs[bad], m_regs[bad]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) dut.ram.memory[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] fl [16];
    int k;
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
           6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    k = int'($urandom_range(0, 9));
    if (k < 4) return rt_op(fl[$urandom_range(0, 15)], int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
    if (k < 9) return it_op(6'($urandom_range(8, 15)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)), 16'($urandom));
    return $urandom;
  endfunction

  typedef struct {
    string       name;
    int          n;
    logic [31:0] p [6];
    int          cr [3];
    logic [31:0] cv [3];
  } vec_t;

  vec_t v [6];

  initial begin
    // Directed vectors: program words, then three register expectations
    v[0].name = "imm";   v[0].n = 3;
    v[0].p  = '{it_op(6'h0d, 1, 0, 16'h8000), it_op(6'h0f, 2, 0, 16'h1234), it_op(6'h09, 3, 1, 16'hFFFF), 0, 0, 0};
    v[0].cr = '{1, 2, 3};  v[0].cv = '{32'h0000_8000, 32'h1234_0000, 32'h0000_7FFF};
    v[1].name = "ovf";   v[1].n = 4;
    v[1].p  = '{it_op(6'h0f, 1, 0, 16'h7FFF), it_op(6'h0d, 1, 1, 16'hFFFF), it_op(6'h08, 2, 1, 16'h0001),
                it_op(6'h09, 3, 1, 16'h0001), 0, 0};
    v[1].cr = '{1, 2, 3};  v[1].cv = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
    v[2].name = "cmp";   v[2].n = 5;
    v[2].p  = '{it_op(6'h09, 1, 0, 16'hFFFF), it_op(6'h0d, 2, 0, 16'h0001), rt_op(6'h2a, 3, 1, 2, 0),
                rt_op(6'h2b, 5, 1, 2, 0), rt_op(6'h22, 4, 2, 1, 0), 0};
    v[2].cr = '{3, 5, 4};  v[2].cv = '{32'h1, 32'h0, 32'h2};
    v[3].name = "shift"; v[3].n = 4;
    v[3].p  = '{it_op(6'h0d, 0, 0, 16'h0005), it_op(6'h0f, 1, 0, 16'h8000), rt_op(6'h03, 2, 0, 1, 4),
                rt_op(6'h02, 3, 0, 1, 4), 0, 0};
    v[3].cr = '{0, 2, 3};  v[3].cv = '{32'h0, 32'hF800_0000, 32'h0800_0000};
    v[4].name = "misc";  v[4].n = 5;
    v[4].p  = '{it_op(6'h0f, 1, 0, 16'h8000), it_op(6'h0d, 2, 0, 16'h0001), rt_op(6'h22, 3, 1, 2, 0),
                it_op(6'h0b, 4, 2, 16'hFFFF), rt_op(6'h07, 5, 2, 1, 0), 0};
    v[4].cr = '{3, 4, 5};  v[4].cv = '{32'h0, 32'h1, 32'hC000_0000};
    v[5].name = "logic"; v[5].n = 4;
    v[5].p  = '{it_op(6'h0d, 1, 0, 16'hF0F0), it_op(6'h0e, 2, 1, 16'hFFFF), rt_op(6'h27, 3, 1, 2, 0),
                it_op(6'h0a, 4, 3, 16'h0000), 0, 0};
    v[5].cr = '{2, 3, 4};  v[5].cv = '{32'h0000_0F0F, 32'hFFFF_0000, 32'h1};

    // Reset hold: a program is present but nothing may execute while rst is low
    clear_mem();
    for (int i = 0; i < 4; i++) dut.ram.memory[i] = it_op(6'h0d, i + 1, 0, 16'h0011);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_pc", dut.openmips.pc, 32'h0);
      chk("hold_regs", dut.openmips.regfile.regs[1] | dut.openmips.regfile.regs[2] |
          dut.openmips.regfile.regs[3] | dut.openmips.regfile.regs[4], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("first_edge_r1", dut.openmips.regfile.regs[1], 32'h11);
    chk("first_edge_pc", dut.openmips.pc, 32'h4);

    for (int t = 0; t < 6; t++) begin
      clear_mem();
      for (int i = 0; i < v[t].n; i++) dut.ram.memory[i] = v[t].p[i];
      do_reset();
      for (int i = 0; i < v[t].n; i++) tick();
      for (int j = 0; j < 3; j++) chk($sformatf("%s_r%0d", v[t].name, v[t].cr[j]),
                                      dut.openmips.regfile.regs[v[t].cr[j]], v[t].cv[j]);
    end

    // Fetch address wraps modulo the RAM size
    clear_mem();
    dut.ram.memory[0] = it_op(6'h09, 1, 1, 16'h0001);
    do_reset();
    for (int i = 0; i < N; i++) tick();
    chk("wrap_before", dut.openmips.regfile.regs[1], 32'h1);
    tick();
    chk("wrap_after", dut.openmips.regfile.regs[1], 32'h2);

    // Random programs, full architectural state checked every cycle
    for (int r = 0; r < 4; r++) begin
      clear_mem();
      for (int i = 0; i < 48; i++) begin
        prog[i] = rand_ins();
        dut.ram.memory[i] = prog[i];
      end
      do_reset();
      for (int i = 0; i < 48; i++) begin
        m_step(prog[i]);
        tick();
        chk_state($sformatf("rand%0d_i%0d", r, i), 32'(4 * (i + 1)));
      end
    end

    // Mid-run reset: asynchronous clear during instruction 5, then identical re-run
    clear_mem();
    for (int i = 0; i < 12; i++) begin
      prog[i] = it_op(6'($urandom_range(9, 15)), i % 7 + 1, int'($urandom_range(0, 7)), 16'($urandom));
      dut.ram.memory[i] = prog[i];
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      m_step(prog[i]);
      tick();
    end
    chk_state("midrst_full", 32'd48);
    snap = m_regs;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_pc", dut.openmips.pc, 32'h0);
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    chk_state("midrst_regs", 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    m_regs = snap;
    chk_state("midrst_rerun", 32'd48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
